rvfi_trace_sink: RTL and testbench

//  Consumer end of the core's RVFI retirement interface: accepts one retired instruction per rvfi_valid

---
 rtl/rvfi_trace_sink.sv | 206 ++++++++++++++++++++
 tb/tb_rvfi_trace_sink.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_trace_sink.sv
// RVFI retirement sink: buffers retired instructions in a FIFO, checks PC continuity and
// sequence, and serialises each record as 32-bit beats. Define RVFI_SINK_OPERANDS_EN to add rs1/rs2/rs3 data beats.
module rvfi_trace_sink #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rvfi_valid,
    input  logic [31:0]              rvfi_insn,
    input  logic [4:0]               rvfi_rs1_addr,
    input  logic [4:0]               rvfi_rs2_addr,
    input  logic [4:0]               rvfi_rs3_addr,
    input  logic [31:0]              rvfi_rs1_rdata,
    input  logic [31:0]              rvfi_rs2_rdata,
    input  logic [31:0]              rvfi_rs3_rdata,
    input  logic [4:0]               rvfi_rd_addr,
    input  logic [31:0]              rvfi_rd_wdata,
    input  logic [31:0]              rvfi_pc_rdata,
    input  logic [31:0]              rvfi_pc_wdata,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [31:0]              trace_data,
    output logic                     trace_last,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         retire_count,
    output logic [CNT_W-1:0]         drop_count,
    output logic [CNT_W-1:0]         pc_err_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
`ifdef RVFI_SINK_OPERANDS_EN
    localparam int NB = 8;
`else
    localparam int NB = 5;
`endif
    localparam logic [2:0] LAST_IDX = 3'(NB - 1);

    typedef struct packed {
        logic        perr;
        logic [7:0]  seq;
        logic [4:0]  rd_addr;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rs3_addr;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] insn;
        logic [31:0] rd_wdata;
`ifdef RVFI_SINK_OPERANDS_EN
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [31:0] rs3_rdata;
`endif
    } rec_t;

    typedef enum logic {IDLE, SEND} state_t;

    rec_t            mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic [7:0]      seq_q;
    logic            pc_seen_q;
    logic [31:0]     last_pc_q;
    logic            overflow_q;
    logic [CNT_W-1:0] retire_q, drop_q, perr_cnt_q;
    state_t          state_q, state_d;
    logic [2:0]      beat_idx_q, beat_idx_d;
    rec_t            cur_q, cur_d;

    logic            push, pop, perr;
    logic [31:0]     beat;
    rec_t            new_rec;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A pop in the same cycle does not free space: admission uses the registered level only.
    assign push = rvfi_valid && (level_q < LW'(DEPTH));
    assign perr = pc_seen_q && (rvfi_pc_rdata != last_pc_q);

    always_comb begin
        new_rec          = '0;
        new_rec.perr     = perr;
        new_rec.seq      = seq_q;
        new_rec.rd_addr  = rvfi_rd_addr;
        new_rec.rs1_addr = rvfi_rs1_addr;
        new_rec.rs2_addr = rvfi_rs2_addr;
        new_rec.rs3_addr = rvfi_rs3_addr;
        new_rec.pc_rdata = rvfi_pc_rdata;
        new_rec.pc_wdata = rvfi_pc_wdata;
        new_rec.insn     = rvfi_insn;
        new_rec.rd_wdata = rvfi_rd_wdata;
`ifdef RVFI_SINK_OPERANDS_EN
        new_rec.rs1_rdata = rvfi_rs1_rdata;
        new_rec.rs2_rdata = rvfi_rs2_rdata;
        new_rec.rs3_rdata = rvfi_rs3_rdata;
`endif
    end

    // NOTE: storage array has no reset; validity is tracked by the pointers and level alone.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= new_rec;
    end

    always_comb begin
        beat = '0;
        case (beat_idx_q)
            3'd0: beat = {3'b101, cur_q.perr, cur_q.seq, cur_q.rd_addr,
                          cur_q.rs1_addr, cur_q.rs2_addr, cur_q.rs3_addr};
            3'd1: beat = cur_q.pc_rdata;
            3'd2: beat = cur_q.pc_wdata;
            3'd3: beat = cur_q.insn;
            3'd4: beat = cur_q.rd_wdata;
`ifdef RVFI_SINK_OPERANDS_EN
            3'd5: beat = cur_q.rs1_rdata;
            3'd6: beat = cur_q.rs2_rdata;
            3'd7: beat = cur_q.rs3_rdata;
`endif
            default: beat = '0;
        endcase
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        beat_idx_d  = beat_idx_q;
        cur_d       = cur_q;
        pop         = 1'b0;
        trace_valid = 1'b0;
        trace_last  = 1'b0;
        trace_data  = '0;
        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    pop        = 1'b1;
                    cur_d      = mem_q[rd_ptr_q];
                    beat_idx_d = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                trace_valid = 1'b1;
                trace_data  = beat;
                trace_last  = (beat_idx_q == LAST_IDX);
                if (trace_ready) begin
                    if (beat_idx_q != LAST_IDX) begin
                        beat_idx_d = beat_idx_q + 3'd1;
                    end else if (level_q != '0) begin
                        pop        = 1'b1;
                        cur_d      = mem_q[rd_ptr_q];
                        beat_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            seq_q      <= '0;
            pc_seen_q  <= 1'b0;
            last_pc_q  <= '0;
            overflow_q <= 1'b0;
            retire_q   <= '0;
            drop_q     <= '0;
            perr_cnt_q <= '0;
            state_q    <= IDLE;
            beat_idx_q <= '0;
            cur_q      <= '0;
        end else begin
            state_q    <= state_d;
            beat_idx_q <= beat_idx_d;
            cur_q      <= cur_d;
            level_q    <= level_q + LW'(push) - LW'(pop);
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (rvfi_valid) begin
                seq_q     <= seq_q + 8'd1;
                retire_q  <= sat_inc(retire_q);
                pc_seen_q <= 1'b1;
                last_pc_q <= rvfi_pc_wdata;
                if (perr) perr_cnt_q <= sat_inc(perr_cnt_q);
                if (!push) begin
                    overflow_q <= 1'b1;
                    drop_q     <= sat_inc(drop_q);
                end
            end
        end
    end

    assign fifo_level   = level_q;
    assign overflow     = overflow_q;
    assign retire_count = retire_q;
    assign drop_count   = drop_q;
    assign pc_err_count = perr_cnt_q;
endmodule

// File: tb/tb_rvfi_trace_sink.sv
// Self-checking bench for rvfi_trace_sink: directed scenarios with randomized fields and
// handshake, compared every cycle against a queue-based transaction model.
module tb_rvfi_trace_sink;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
`ifdef RVFI_SINK_OPERANDS_EN
    localparam int NB = 8;
`else
    localparam int NB = 5;
`endif
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk, reset, rvfi_valid, trace_valid, trace_ready, trace_last, overflow;
    logic [31:0] rvfi_insn, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rs3_rdata;
    logic [31:0] rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata, trace_data;
    logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs3_addr, rvfi_rd_addr;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [CNT_W-1:0] retire_count, drop_count, pc_err_count;

    rvfi_trace_sink #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .rvfi_valid(rvfi_valid), .rvfi_insn(rvfi_insn),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rs3_addr(rvfi_rs3_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rs3_rdata(rvfi_rs3_rdata), .rvfi_rd_addr(rvfi_rd_addr),
        .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_pc_rdata(rvfi_pc_rdata),
        .rvfi_pc_wdata(rvfi_pc_wdata), .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_data(trace_data), .trace_last(trace_last), .fifo_level(fifo_level),
        .overflow(overflow), .retire_count(retire_count), .drop_count(drop_count),
        .pc_err_count(pc_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: each record is its list of beats, packed 32 bits per beat.
    logic [255:0] m_q[$];
    logic [255:0] m_cur;
    bit           m_busy;
    int           m_idx;
    logic [7:0]   m_seq;
    bit           m_pc_seen;
    logic [31:0]  m_last_pc;
    int           m_ret, m_drop, m_perr;
    bit           m_ovf;
    logic [31:0]  gen_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_cur = '0; m_busy = 0; m_idx = 0; m_seq = '0; m_pc_seen = 0; m_last_pc = '0;
        m_ret = 0; m_drop = 0; m_perr = 0; m_ovf = 0;
    endtask

    task automatic model_edge();
        int sz;
        bit hs, pop, perr;
        logic [255:0] rec;
        if (reset) begin
            model_reset();
            return;
        end
        sz  = m_q.size();
        hs  = m_busy && trace_ready;
        pop = (sz > 0) && (!m_busy || (hs && m_idx == NB - 1));
        rec = '0;
        if (rvfi_valid) begin
            perr = m_pc_seen && (rvfi_pc_rdata != m_last_pc);
            rec[31:0]    = {3'b101, perr, m_seq, rvfi_rd_addr, rvfi_rs1_addr,
                            rvfi_rs2_addr, rvfi_rs3_addr};
            rec[63:32]   = rvfi_pc_rdata;
            rec[95:64]   = rvfi_pc_wdata;
            rec[127:96]  = rvfi_insn;
            rec[159:128] = rvfi_rd_wdata;
            rec[191:160] = rvfi_rs1_rdata;
            rec[223:192] = rvfi_rs2_rdata;
            rec[255:224] = rvfi_rs3_rdata;
            if (perr) m_perr = sat(m_perr);
            m_pc_seen = 1; m_last_pc = rvfi_pc_wdata;
            m_seq = m_seq + 8'd1;
            m_ret = sat(m_ret);
        end
        if (pop) begin
            m_cur = m_q.pop_front(); m_busy = 1; m_idx = 0;
        end else if (hs) begin
            if (m_idx == NB - 1) m_busy = 0;
            else m_idx++;
        end
        if (rvfi_valid) begin
            if (sz < DEPTH) m_q.push_back(rec);
            else begin m_drop = sat(m_drop); m_ovf = 1; end
        end
    endtask

    // Compare all outputs against the model, then advance one clock.
    task automatic tick();
        check("trace_valid", 32'(trace_valid), 32'(m_busy));
        check("trace_last", 32'(trace_last), 32'(m_busy && m_idx == NB - 1));
        check("trace_data", trace_data, m_busy ? m_cur[m_idx*32 +: 32] : 32'h0);
        check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("retire_count", 32'(retire_count), 32'(m_ret));
        check("drop_count", 32'(drop_count), 32'(m_drop));
        check("pc_err_count", 32'(pc_err_count), 32'(m_perr));
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_retire();
        rvfi_valid     = 1'b1;
        rvfi_insn      = $urandom;
        rvfi_rs1_addr  = 5'($urandom); rvfi_rs2_addr = 5'($urandom);
        rvfi_rs3_addr  = 5'($urandom); rvfi_rd_addr  = 5'($urandom);
        rvfi_rs1_rdata = $urandom; rvfi_rs2_rdata = $urandom; rvfi_rs3_rdata = $urandom;
        rvfi_rd_wdata  = $urandom;
        rvfi_pc_rdata  = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC) : gen_pc;
        rvfi_pc_wdata  = ($urandom_range(0, 5) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                                     : rvfi_pc_rdata + 32'd4;
        gen_pc = rvfi_pc_wdata;
    endtask

    task automatic drain();
        rvfi_valid  = 1'b0;
        trace_ready = 1'b1;
        for (int i = 0; i < 200 && (m_busy || m_q.size() != 0); i++) tick();
        check("drain_done", 32'(m_busy || m_q.size() != 0), 32'h0);
        tick();
    endtask

    task automatic reset_dut();
        reset = 1'b1; rvfi_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rvfi_valid = 1'b0; trace_ready = 1'b0; gen_pc = 32'h100;
        rvfi_insn = '0; rvfi_rs1_addr = '0; rvfi_rs2_addr = '0; rvfi_rs3_addr = '0;
        rvfi_rd_addr = '0; rvfi_rs1_rdata = '0; rvfi_rs2_rdata = '0; rvfi_rs3_rdata = '0;
        rvfi_rd_wdata = '0; rvfi_pc_rdata = '0; rvfi_pc_wdata = '0;
        @(posedge clk);
        #1;
        model_reset();
        tick();
        reset = 1'b0;

        // Single retire: header appears two cycles after capture.
        trace_ready = 1'b1;
        rand_retire();
        rvfi_pc_rdata = 32'h100; rvfi_pc_wdata = 32'h104; rvfi_insn = 32'h00B5_0533;
        rvfi_rd_addr = 5'd10; rvfi_rs1_addr = 5'd10; rvfi_rs2_addr = 5'd11; rvfi_rs3_addr = 5'd0;
        tick();
        rvfi_valid = 1'b0;
        tick();
        check("t1_hdr_valid", 32'(trace_valid), 32'h1);
        check("t1_hdr", trace_data, 32'hA005_2960);
        drain();

        // PC discontinuity flags the second record.
        reset_dut();
        rand_retire(); rvfi_pc_rdata = 32'h100; rvfi_pc_wdata = 32'h104;
        tick();
        rand_retire(); rvfi_pc_rdata = 32'h200; rvfi_pc_wdata = 32'h204;
        tick();
        drain();
        check("t2_pc_err_count", 32'(pc_err_count), 32'h1);

        // Stalled sink: shifter holds one, FIFO fills, the last is dropped.
        reset_dut();
        trace_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin rand_retire(); tick(); end
        rvfi_valid = 1'b0;
        tick();
        check("t3_level", 32'(fifo_level), 32'(DEPTH));
        check("t3_drops", 32'(drop_count), 32'h1);
        check("t3_overflow", 32'(overflow), 32'h1);
        drain();

        // Random backpressure mid-record.
        reset_dut();
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 9) < 4) rand_retire(); else rvfi_valid = 1'b0;
            trace_ready = 1'($urandom_range(0, 1));
            tick();
        end
        drain();

        // Reset on beat 2 of a record aborts it.
        reset_dut();
        trace_ready = 1'b1;
        rand_retire();
        tick();
        rvfi_valid = 1'b0;
        for (int i = 0; i < 10 && !(m_busy && m_idx == 2); i++) tick();
        check("t5_at_beat2", 32'(m_busy && m_idx == 2), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_valid", 32'(trace_valid), 32'h0);
        check("t5_retire", 32'(retire_count), 32'h0);
        tick();
        rand_retire();
        tick();
        drain();

        // 256 retires: sequence wraps, counter reaches 256.
        reset_dut();
        for (int i = 0; i < 256; i++) begin
            rand_retire();
            trace_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();
        check("t6_retire_count", 32'(retire_count), 32'd256);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
